inv_shift_mix_round: RTL

Inverse-cipher round datapath for AES decryption. It is the counterpart of the encrypt-side registered ShiftRows stage. It performs InvShiftRows, then AddRoundKey, then InvMixColumns, which is bypassed on the last round, in a 2-stage valid/ready pipeline. InvSubBytes is a separate block placed between this block's input source and the round-key XOR by the top-level integration. This block owns only the permutation, key mix and column arithmetic.

---
 rtl/inv_shift_mix_round.sv | 115 +++++++++++
 1 files changed

// File: rtl/inv_shift_mix_round.sv
// ============================================================================
//  Module      : inv_shift_mix_round
//  Description : AES inverse round datapath: InvShiftRows -> AddRoundKey ->
//                InvMixColumns (bypassed on last round), 2-stage valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_shift_mix_round #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [BLOCK_LENGTH-1:0] IN_DATA,
    input  logic [BLOCK_LENGTH-1:0] ROUND_KEY,
    input  logic                    LAST_ROUND,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [BLOCK_LENGTH-1:0] OUT_DATA
);

    localparam int c_NCOL = 4;
    localparam int c_NROW = 4;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/b/d/e are assembled from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic [BLOCK_LENGTH-1:0] r_s1_data;
    logic [BLOCK_LENGTH-1:0] r_s1_key;
    logic                    r_s2_valid;
    logic [BLOCK_LENGTH-1:0] r_s2_data;

    logic                    w_ld1;
    logic                    w_ld2;
    logic [BLOCK_LENGTH-1:0] w_shifted;
    logic [BLOCK_LENGTH-1:0] w_keyed;
    logic [BLOCK_LENGTH-1:0] w_mixed;

    assign w_ld2    = !r_s2_valid || OUT_READY;
    assign w_ld1    = !r_s1_valid || w_ld2;
    assign IN_READY = w_ld1;

    assign w_keyed  = r_s1_data ^ r_s1_key;

    generate
        for (genvar c = 0; c < c_NCOL; c++) begin : g_col
            // Row r of output column c comes from input column (c - r) mod 4.
            for (genvar r = 0; r < c_NROW; r++) begin : g_row
                assign w_shifted[BLOCK_LENGTH-1-8*(4*c+r) -: 8] =
                    IN_DATA[BLOCK_LENGTH-1-8*(4*((c-r+4)%4)+r) -: 8];
            end
            assign w_mixed[BLOCK_LENGTH-1-32*c -: 32] =
                inv_mix_col(w_keyed[BLOCK_LENGTH-1-32*c -: 32]);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
            r_s1_key   <= '0;
        end else if (w_ld1) begin
            r_s1_valid <= IN_VALID;
            r_s1_last  <= LAST_ROUND;
            r_s1_data  <= w_shifted;
            r_s1_key   <= ROUND_KEY;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_ld2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= r_s1_last ? w_keyed : w_mixed;
        end
    end

    assign OUT_VALID = r_s2_valid;
    assign OUT_DATA  = r_s2_data;

endmodule

`default_nettype wire
